// File: rtl/sd_asplit2_pkg.sv
// Shared definitions for the asymmetric split: clocking macros, the
// branch-buffer occupancy encoding and its update helper.

`ifndef SDLIB_CLOCKING
`define SDLIB_CLOCKING posedge clk or posedge reset
`endif

`ifndef SDLIB_DELAY
`define SDLIB_DELAY
`endif

package sd_asplit2_pkg;

    // Default field widths of the concatenated upstream word.
    localparam int P1_WIDTH_DEF = 8;
    localparam int P2_WIDTH_DEF = 8;

    // Occupancy of one 2-entry branch buffer; this is the buffer's state.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_TWO   = 2'd2
    } slot_cnt_e;

    // Next occupancy given one optional push and one optional pop.
    // Callers guarantee push never lands on a full buffer and pop never
    // hits an empty one, so the result always stays within 0..2.
    function automatic slot_cnt_e cnt_next(slot_cnt_e cnt, logic push, logic pop);
        logic [1:0] v;
        v = 2'(cnt) + {1'b0, push} - {1'b0, pop};
        return slot_cnt_e'(v);
    endfunction

endpackage

// File: rtl/sd_asplit_slot.sv
// Two-entry branch buffer. Head register always drives the output directly,
// tail register holds the second word while the consumer is stalled.
//
// Handshake: a word moves when the producer's srdy and the consumer's drdy
// are both high at a rising clock edge; push_i/pop_i here are already those
// qualified transfer strobes, and srdy_o/full_o come from flops only.

module sd_asplit_slot
    import sd_asplit2_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] data_i,
    input  logic             pop_i,
    output logic             srdy_o,
    output logic [width-1:0] data_o,
    output logic             full_o
);

    slot_cnt_e        cnt_q;
    logic [width-1:0] head_q;
    logic [width-1:0] tail_q;

    logic push_ok;
    logic pop_ok;

    // A push on a full buffer or a pop on an empty one is ignored so the
    // occupancy can never leave 0..2 even if a caller misbehaves.
    assign push_ok = push_i & (cnt_q != SLOT_TWO);
    assign pop_ok  = pop_i  & (cnt_q != SLOT_EMPTY);

    assign srdy_o = (cnt_q != SLOT_EMPTY);
    assign full_o = (cnt_q == SLOT_TWO);
    assign data_o = head_q;

    // Occupancy state machine with head/tail steering.
    always_ff @(`SDLIB_CLOCKING) begin
        if (reset) begin
            cnt_q  <= `SDLIB_DELAY SLOT_EMPTY;
            head_q <= `SDLIB_DELAY '0;
            tail_q <= `SDLIB_DELAY '0;
        end else begin
            cnt_q <= `SDLIB_DELAY cnt_next(cnt_q, push_ok, pop_ok);
            case (cnt_q)
                SLOT_EMPTY: begin
                    if (push_ok) head_q <= `SDLIB_DELAY data_i;
                end
                SLOT_ONE: begin
                    // With a simultaneous pop the new word becomes head at once.
                    if (push_ok && pop_ok)  head_q <= `SDLIB_DELAY data_i;
                    else if (push_ok)       tail_q <= `SDLIB_DELAY data_i;
                end
                SLOT_TWO: begin
                    if (pop_ok) begin
                        head_q <= `SDLIB_DELAY tail_q;
                        if (push_ok) tail_q <= `SDLIB_DELAY data_i;
                    end
                end
                default: begin
                    cnt_q <= `SDLIB_DELAY SLOT_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/sd_asplit2.sv
// Asymmetric split: one concatenated upstream word is written into two
// independent branch buffers, low field to port 1, high field to port 2.
//
// Handshake: every port transfers on a rising edge where its srdy and drdy
// are both high. c_drdy depends only on buffer occupancy flops, so there is
// no combinational path from either p*_drdy back to c_drdy.

module sd_asplit2
    import sd_asplit2_pkg::*;
#(
    parameter int p1_width = P1_WIDTH_DEF,
    parameter int p2_width = P2_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         c_srdy,
    output logic                         c_drdy,
    input  logic [p1_width+p2_width-1:0] c_data,
    output logic                         p1_srdy,
    input  logic                         p1_drdy,
    output logic [p1_width-1:0]          p1_data,
    output logic                         p2_srdy,
    input  logic                         p2_drdy,
    output logic [p2_width-1:0]          p2_data
);

    logic full_1;
    logic full_2;
    logic c_xfer;

    // Upstream may only transfer when both branches have room, so the
    // two fields of a word always enter their buffers together.
    assign c_drdy = ~full_1 & ~full_2;
    assign c_xfer = c_srdy & c_drdy;

    sd_asplit_slot #(
        .width (p1_width)
    ) u_slot_1 (
        .clk    (clk),
        .reset  (reset),
        .push_i (c_xfer),
        .data_i (c_data[p1_width-1:0]),
        .pop_i  (p1_srdy & p1_drdy),
        .srdy_o (p1_srdy),
        .data_o (p1_data),
        .full_o (full_1)
    );

    sd_asplit_slot #(
        .width (p2_width)
    ) u_slot_2 (
        .clk    (clk),
        .reset  (reset),
        .push_i (c_xfer),
        .data_i (c_data[p1_width+p2_width-1:p1_width]),
        .pop_i  (p2_srdy & p2_drdy),
        .srdy_o (p2_srdy),
        .data_o (p2_data),
        .full_o (full_2)
    );

endmodule

// File: tb/tb_sd_asplit2.sv
// Bench for sd_asplit2: directed stimulus, queue scoreboard per branch,
// monitor on the falling edge compares every visible output.

module tb_sd_asplit2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_srdy = 1'b0;
  logic        c_drdy;
  logic [15:0] c_data = '0;
  logic        p1_srdy;
  logic        p1_drdy = 1'b0;
  logic [7:0]  p1_data;
  logic        p2_srdy;
  logic        p2_drdy = 1'b0;
  logic [7:0]  p2_data;

  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];

  int total = 0;
  int bad = 0;

  sd_asplit2 #(.p1_width(8), .p2_width(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
    .p1_srdy (p1_srdy),
    .p1_drdy (p1_drdy),
    .p1_data (p1_data),
    .p2_srdy (p2_srdy),
    .p2_drdy (p2_drdy),
    .p2_data (p2_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard: compare, then retire pops and record accepted pushes
  always @(negedge clk) begin
    logic exp_drdy;
    if (!reset) begin
      exp_drdy = (exp1_q.size() < 2) && (exp2_q.size() < 2);
      chk("c_drdy", {15'd0, c_drdy}, {15'd0, exp_drdy});
      chk("p1_srdy", {15'd0, p1_srdy}, {15'd0, exp1_q.size() != 0});
      chk("p2_srdy", {15'd0, p2_srdy}, {15'd0, exp2_q.size() != 0});
      if (exp1_q.size() != 0) chk("p1_data", {8'd0, p1_data}, {8'd0, exp1_q[0]});
      if (exp2_q.size() != 0) chk("p2_data", {8'd0, p2_data}, {8'd0, exp2_q[0]});
      if (p1_drdy && exp1_q.size() != 0) void'(exp1_q.pop_front());
      if (p2_drdy && exp2_q.size() != 0) void'(exp2_q.pop_front());
      if (c_srdy && exp_drdy) begin
        exp1_q.push_back(c_data[7:0]);
        exp2_q.push_back(c_data[15:8]);
      end
    end
  end

  // driver: present one word and hold it until it is accepted
  task automatic send(input logic [15:0] w);
    int n;
    logic ok;
    n = 0;
    c_srdy = 1'b1;
    c_data = w;
    forever begin
      @(negedge clk);
      ok = c_drdy;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 16'd0, 16'd1);
        break;
      end
    end
    c_srdy = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    p1_drdy = 1'b1;
    p2_drdy = 1'b1;
    while ((exp1_q.size() != 0 || exp2_q.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", {15'd0, n < 40}, 16'd1);
    @(negedge clk);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_c_drdy", {15'd0, c_drdy}, 16'd1);
    chk("rst_p1_srdy", {15'd0, p1_srdy}, 16'd0);
    chk("rst_p2_srdy", {15'd0, p2_srdy}, 16'd0);
    chk("rst_p1_data", {8'd0, p1_data}, 16'd0);
    chk("rst_p2_data", {8'd0, p2_data}, 16'd0);
    #9 reset = 1'b0;
    @(posedge clk);
    #1;

    // single word
    p1_drdy = 1'b1;
    p2_drdy = 1'b1;
    send(16'hB2A1);
    @(negedge clk);
    chk("t1_p1_data", {8'd0, p1_data}, 16'h00A1);
    chk("t1_p2_data", {8'd0, p2_data}, 16'h00B2);
    chk("t1_srdy", {14'd0, p2_srdy, p1_srdy}, 16'h0003);
    @(negedge clk);
    chk("t1_empty", {14'd0, p2_srdy, p1_srdy}, 16'h0000);
    @(posedge clk);
    #1;

    // streaming
    for (int i = 0; i < 8; i++) send({8'(i + 1), 8'(i)});
    @(negedge clk);
    chk("t2_last_p1", {8'd0, p1_data}, 16'h0007);
    chk("t2_last_p2", {8'd0, p2_data}, 16'h0008);
    drain();

    // skew: p2 stalled, third word waits for the first p2 pop
    @(posedge clk);
    #1;
    p1_drdy = 1'b1;
    p2_drdy = 1'b0;
    fork
      begin
        send(16'h5141);
        send(16'h5242);
        send(16'h5343);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t3_blocked", {15'd0, c_drdy}, 16'd0);
        chk("t3_p2_head", {8'd0, p2_data}, 16'h0051);
        chk("t3_p1_empty", {15'd0, p1_srdy}, 16'd0);
        @(posedge clk);
        #1;
        p2_drdy = 1'b1;
      end
    join
    drain();

    // push and pop together at one entry
    @(posedge clk);
    #1;
    p1_drdy = 1'b0;
    p2_drdy = 1'b0;
    send(16'h2211);
    p1_drdy = 1'b1;
    p2_drdy = 1'b1;
    send(16'h4433);
    p1_drdy = 1'b0;
    p2_drdy = 1'b0;
    @(negedge clk);
    chk("t4_p1_head", {8'd0, p1_data}, 16'h0033);
    chk("t4_p2_head", {8'd0, p2_data}, 16'h0044);
    drain();

    // push blocked when full
    @(posedge clk);
    #1;
    p1_drdy = 1'b0;
    p2_drdy = 1'b0;
    send(16'hA0B0);
    send(16'hA1B1);
    c_srdy = 1'b1;
    c_data = 16'hFFEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_c_drdy", {15'd0, c_drdy}, 16'd0);
      chk("t5_p1_hold", {8'd0, p1_data}, 16'h00B0);
      chk("t5_p2_hold", {8'd0, p2_data}, 16'h00A0);
    end
    @(posedge clk);
    #1;
    c_srdy = 1'b0;
    drain();

    // reset mid-operation: branch 1 holds two words, branch 2 holds one
    @(posedge clk);
    #1;
    p1_drdy = 1'b0;
    p2_drdy = 1'b0;
    send(16'hC1D1);
    p2_drdy = 1'b1;
    send(16'hC2D2);
    p2_drdy = 1'b0;
    #1;
    reset = 1'b1;
    exp1_q.delete();
    exp2_q.delete();
    #1;
    chk("t6_p1_srdy", {15'd0, p1_srdy}, 16'd0);
    chk("t6_p2_srdy", {15'd0, p2_srdy}, 16'd0);
    chk("t6_c_drdy", {15'd0, c_drdy}, 16'd1);
    chk("t6_data", {p2_data, p1_data}, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    p1_drdy = 1'b1;
    p2_drdy = 1'b1;
    send(16'h7766);
    @(negedge clk);
    chk("t6_after_p1", {8'd0, p1_data}, 16'h0066);
    chk("t6_after_p2", {8'd0, p2_data}, 16'h0077);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
